// File: rtl/tick_bcd_counter.sv
// Two-digit BCD counter advanced by rising edges of a slow tick level.
// A three-state run/pause controller gates which ticks are counted.
module tick_bcd_counter #(
    parameter int unsigned TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_src,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic       running
);

    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state;
    logic   tick_q;
    logic   tick_c;

    assign tick_c = tick_src & ~tick_q;

    // Controller, digit registers and edge-detect history share one register block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tick_q  <= 1'b0;
            ones    <= '0;
            tens    <= '0;
            carry   <= 1'b0;
            running <= 1'b0;
        end else begin
            tick_q <= tick_src;
            carry  <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                running <= 1'b0;
                ones    <= '0;
                tens    <= '0;
            end else begin
                case (state)
                    IDLE, PAUSE: begin
                        // stop outranks start, so both together never resume
                        if (!stop && start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick_c) begin
                            if (ones != DW'(9)) begin
                                ones <= ones + DW'(1);
                            end else begin
                                ones <= '0;
                                if (tens == DW'(TENS_MAX)) begin
                                    tens  <= '0;
                                    carry <= 1'b1;
                                end else begin
                                    tens <= tens + DW'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter; a second instance with TENS_MAX=2
// shares the stimulus and is checked only in the narrow-wrap scenario.
module tb_tick_bcd_counter;

    logic       clk;
    logic       reset;
    logic       tick_src;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       carry;
    logic       running;
    logic [3:0] ones2;
    logic [3:0] tens2;
    logic       carry2;
    logic       running2;

    int chk_cnt;
    int pass_cnt;
    int c5_cnt;
    int c2_cnt;

    tick_bcd_counter #(.TENS_MAX(5)) dut (
        .clk(clk), .reset(reset), .tick_src(tick_src), .start(start),
        .stop(stop), .clear(clear), .ones(ones), .tens(tens),
        .carry(carry), .running(running)
    );

    tick_bcd_counter #(.TENS_MAX(2)) dut2 (
        .clk(clk), .reset(reset), .tick_src(tick_src), .start(start),
        .stop(stop), .clear(clear), .ones(ones2), .tens(tens2),
        .carry(carry2), .running(running2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All helpers start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick_src = 1'b1;
        step();
        if (carry)  c5_cnt++;
        if (carry2) c2_cnt++;
        tick_src = 1'b0;
        step();
        if (carry)  c5_cnt++;
        if (carry2) c2_cnt++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    task automatic cmd(input logic s_start, input logic s_stop, input logic s_clear);
        start = s_start;
        stop  = s_stop;
        clear = s_clear;
        step();
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; tick_src = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        #2;
        chk_cnt++;
        if ({tens, ones, carry, running} !== 10'd0)
            $display("FAIL reset_outputs got tens=%0d ones=%0d carry=%0b running=%0b exp all 0", tens, ones, carry, running);
        else pass_cnt++;
        step();
        step();
        // release with tick_src already high: IDLE must ignore it
        tick_src = 1'b1;
        reset    = 1'b1;
        step();
        cmd(1'b1, 1'b0, 1'b0);
        step();
        chk_cnt++;
        if (running !== 1'b1 || ones !== 4'd0)
            $display("FAIL reset_release_start got running=%0b ones=%0d exp 1,0", running, ones);
        else pass_cnt++;
        tick_src = 1'b0;
        step();
        tick_once();
        chk_cnt++;
        if (ones !== 4'd1 || tens !== 4'd0)
            $display("FAIL reset_first_tick got %0d%0d exp 01", tens, ones);
        else pass_cnt++;
    endtask

    task automatic test_count10();
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        c5_cnt = 0;
        tick_n(10);
        chk_cnt++;
        if (tens !== 4'd1 || ones !== 4'd0 || c5_cnt !== 0 || running !== 1'b1)
            $display("FAIL count10 got %0d%0d carries=%0d running=%0b exp 10,0,1", tens, ones, c5_cnt, running);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        c5_cnt = 0;
        tick_n(59);
        chk_cnt++;
        if (tens !== 4'd5 || ones !== 4'd9 || c5_cnt !== 0)
            $display("FAIL wrap_59 got %0d%0d carries=%0d exp 59,0", tens, ones, c5_cnt);
        else pass_cnt++;
        tick_src = 1'b1;
        step();
        chk_cnt++;
        if (tens !== 4'd0 || ones !== 4'd0 || carry !== 1'b1)
            $display("FAIL wrap_00 got %0d%0d carry=%0b exp 00,1", tens, ones, carry);
        else pass_cnt++;
        tick_src = 1'b0;
        step();
        chk_cnt++;
        if (carry !== 1'b0)
            $display("FAIL wrap_carry_one_cycle got %0b exp 0", carry);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        tick_n(7);
        cmd(1'b0, 1'b1, 1'b0);
        tick_n(5);
        chk_cnt++;
        if (tens !== 4'd0 || ones !== 4'd7 || running !== 1'b0)
            $display("FAIL pause_hold got %0d%0d running=%0b exp 07,0", tens, ones, running);
        else pass_cnt++;
        cmd(1'b1, 1'b0, 1'b0);
        tick_once();
        chk_cnt++;
        if (tens !== 4'd0 || ones !== 4'd8 || running !== 1'b1)
            $display("FAIL pause_resume got %0d%0d running=%0b exp 08,1", tens, ones, running);
        else pass_cnt++;
    endtask

    task automatic test_controls();
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b1, 1'b0);
        chk_cnt++;
        if (running !== 1'b0)
            $display("FAIL start_stop_together got running=%0b exp 0", running);
        else pass_cnt++;
        cmd(1'b1, 1'b0, 1'b0);
        tick_n(12);
        tick_src = 1'b1;
        stop     = 1'b1;
        step();
        tick_src = 1'b0;
        stop     = 1'b0;
        step();
        chk_cnt++;
        if (tens !== 4'd1 || ones !== 4'd2 || running !== 1'b0)
            $display("FAIL stop_with_tick got %0d%0d running=%0b exp 12,0", tens, ones, running);
        else pass_cnt++;
        cmd(1'b1, 1'b0, 1'b0);
        tick_n(22);
        chk_cnt++;
        if (tens !== 4'd3 || ones !== 4'd4)
            $display("FAIL count34 got %0d%0d exp 34", tens, ones);
        else pass_cnt++;
        tick_src = 1'b1;
        clear    = 1'b1;
        step();
        tick_src = 1'b0;
        clear    = 1'b0;
        chk_cnt++;
        if (tens !== 4'd0 || ones !== 4'd0 || running !== 1'b0 || carry !== 1'b0)
            $display("FAIL clear_in_run got %0d%0d running=%0b carry=%0b exp 00,0,0", tens, ones, running, carry);
        else pass_cnt++;
        cmd(1'b1, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 1'b1);
        chk_cnt++;
        if (running !== 1'b0)
            $display("FAIL clear_with_start got running=%0b exp 0", running);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        c5_cnt = 0;
        tick_n(42);
        chk_cnt++;
        if (tens !== 4'd4 || ones !== 4'd2)
            $display("FAIL count42 got %0d%0d exp 42", tens, ones);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        chk_cnt++;
        if ({tens, ones, carry, running} !== 10'd0)
            $display("FAIL async_reset got tens=%0d ones=%0d carry=%0b running=%0b exp all 0", tens, ones, carry, running);
        else pass_cnt++;
        tick_src = 1'b1;
        step();
        reset = 1'b1;
        step();
        cmd(1'b1, 1'b0, 1'b0);
        step();
        step();
        chk_cnt++;
        if (tens !== 4'd0 || ones !== 4'd0 || running !== 1'b1 || c5_cnt !== 0)
            $display("FAIL start_tick_high got %0d%0d running=%0b carries=%0d exp 00,1,0", tens, ones, running, c5_cnt);
        else pass_cnt++;
        tick_src = 1'b0;
        step();
        tick_once();
        chk_cnt++;
        if (tens !== 4'd0 || ones !== 4'd1)
            $display("FAIL after_new_edge got %0d%0d exp 01", tens, ones);
        else pass_cnt++;
    endtask

    task automatic test_tens2();
        logic [3:0] held;
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        c2_cnt = 0;
        tick_n(29);
        chk_cnt++;
        if (tens2 !== 4'd2 || ones2 !== 4'd9 || c2_cnt !== 0)
            $display("FAIL t2_29 got %0d%0d carries=%0d exp 29,0", tens2, ones2, c2_cnt);
        else pass_cnt++;
        tick_once();
        chk_cnt++;
        if (tens2 !== 4'd0 || ones2 !== 4'd0 || c2_cnt !== 1)
            $display("FAIL t2_wrap got %0d%0d carries=%0d exp 00,1", tens2, ones2, c2_cnt);
        else pass_cnt++;
        tick_src = 1'b1;
        step();
        held = ones2;
        tick_src = 1'b0;
        step();
        step();
        step();
        chk_cnt++;
        if (ones2 !== 4'd1 || held !== 4'd1)
            $display("FAIL t2_fall_edge got %0d (held %0d) exp 1", ones2, held);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        c5_cnt   = 0;
        c2_cnt   = 0;
        test_reset();
        test_count10();
        test_wrap();
        test_pause();
        test_controls();
        test_async_reset();
        test_tens2();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
